// File: rtl/trivium_stream_ctrl.sv
// trivium_stream_ctrl
// Sequencer for one bit-serial Trivium cipher_engine. It takes a key and IV
// through a start handshake, loads them into the engine and runs the warm-up
// phase. It then streams data bytes through the engine one bit per clock,
// LSB first, and reassembles each result byte for the output stream.
// Optional build macro TRIVIUM_STREAM_CTRL_KS_CNT_EN adds ks_cnt_o, a
// saturating count of output bytes delivered since the last start.
module trivium_stream_ctrl #(
    parameter int WARMUP_CYC = 1152,
    parameter int DW         = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    output logic          start_ready_o,
    input  logic [79:0]   key_i,
    input  logic [79:0]   iv_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_dat_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_dat_o,
    output logic          busy_o,
    output logic          eng_ce_o,
    output logic          eng_ld_o,
    output logic [79:0]   eng_key_o,
    output logic [79:0]   eng_iv_o,
    output logic          eng_dat_o,
    input  logic          eng_dat_i
`ifdef TRIVIUM_STREAM_CTRL_KS_CNT_EN
    ,
    output logic [31:0]   ks_cnt_o
`endif
);

    localparam int CW = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
    localparam int IW = (DW > 1) ? $clog2(DW) : 1;

    localparam logic [CW-1:0] WARM_LAST = CW'(WARMUP_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DW - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_WARMUP = 3'd2;
    localparam logic [2:0] S_READY  = 3'd3;
    localparam logic [2:0] S_SHIFT  = 3'd4;
    localparam logic [2:0] S_OUT    = 3'd5;

    logic [2:0]    state;
    logic [CW-1:0] warm_cnt;
    logic [IW-1:0] bit_idx;
    logic [DW-1:0] in_byte;
    logic [DW-1:0] out_sr;
    logic [79:0]   key_q;
    logic [79:0]   iv_q;

    logic start_acc;
    logic in_acc;
    logic out_acc;

    // Start takes priority over a data byte offered in the same READY cycle.
    assign start_ready_o = (state == S_IDLE) || (state == S_READY);
    assign in_ready_o    = (state == S_READY) && !start_i;
    assign start_acc     = start_i && start_ready_o;
    assign in_acc        = in_valid_i && in_ready_o;
    assign out_acc       = (state == S_OUT) && out_ready_i;

    assign out_valid_o = (state == S_OUT);
    assign out_dat_o   = out_sr;
    assign busy_o      = (state == S_LOAD) || (state == S_WARMUP) || (state == S_SHIFT);

    // The engine only advances while loading, warming up or shifting a byte;
    // in READY and OUT its state is frozen so the keystream is not wasted.
    assign eng_ce_o  = busy_o;
    assign eng_ld_o  = (state == S_LOAD);
    assign eng_key_o = key_q;
    assign eng_iv_o  = iv_q;
    assign eng_dat_o = (state == S_SHIFT) ? in_byte[bit_idx] : 1'b0;

    // Main sequencer: rekey, warm-up count, bit-serial shift and output hold.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            warm_cnt <= '0;
            bit_idx  <= '0;
            in_byte  <= '0;
            out_sr   <= '0;
            key_q    <= '0;
            iv_q     <= '0;
        end else begin
            case (state)
                S_IDLE, S_READY: begin
                    if (start_acc) begin
                        key_q <= key_i;
                        iv_q  <= iv_i;
                        state <= S_LOAD;
                    end else if (in_acc) begin
                        in_byte <= in_dat_i;
                        bit_idx <= '0;
                        state   <= S_SHIFT;
                    end
                end
                S_LOAD: begin
                    warm_cnt <= '0;
                    state    <= S_WARMUP;
                end
                S_WARMUP: begin
                    warm_cnt <= warm_cnt + CW'(1);
                    if (warm_cnt == WARM_LAST) begin
                        state <= S_READY;
                    end
                end
                S_SHIFT: begin
                    out_sr[bit_idx] <= eng_dat_i;
                    bit_idx         <= bit_idx + IW'(1);
                    if (bit_idx == IDX_LAST) begin
                        state <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_acc) begin
                        state <= S_READY;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef TRIVIUM_STREAM_CTRL_KS_CNT_EN
    logic [31:0] ks_cnt;

    assign ks_cnt_o = ks_cnt;

    // Count delivered bytes since the last rekey, saturating at all-ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ks_cnt <= '0;
        end else if (start_acc) begin
            ks_cnt <= '0;
        end else if (out_acc && (ks_cnt != 32'hFFFF_FFFF)) begin
            ks_cnt <= ks_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_trivium_stream_ctrl.sv
// tb_trivium_stream_ctrl
// Bench for trivium_stream_ctrl. A behavioural Trivium engine sits on the
// eng_* ports; a separate software run of the same cipher gives golden
// keystream bytes. Build with TRIVIUM_STREAM_CTRL_KS_CNT_EN to cover ks_cnt_o.
module tb_trivium_stream_ctrl;

    localparam int DW = 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic          start_ready_o;
    logic [79:0]   key_i = '0;
    logic [79:0]   iv_i = '0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [DW-1:0] in_dat_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b1;
    logic [DW-1:0] out_dat_o;
    logic          busy_o;
    logic          eng_ce_o;
    logic          eng_ld_o;
    logic [79:0]   eng_key_o;
    logic [79:0]   eng_iv_o;
    logic          eng_dat_o;
    logic          eng_dat_i;
`ifdef TRIVIUM_STREAM_CTRL_KS_CNT_EN
    logic [31:0]   ks_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    localparam logic [79:0] KEY_A = 80'h0123456789ABCDEF0123;
    localparam logic [79:0] IV_A  = 80'hFEDCBA9876543210FEDC;

    trivium_stream_ctrl #(.WARMUP_CYC(1152), .DW(DW)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .start_ready_o (start_ready_o),
        .key_i         (key_i),
        .iv_i          (iv_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .in_dat_i      (in_dat_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_dat_o     (out_dat_o),
        .busy_o        (busy_o),
        .eng_ce_o      (eng_ce_o),
        .eng_ld_o      (eng_ld_o),
        .eng_key_o     (eng_key_o),
        .eng_iv_o      (eng_iv_o),
        .eng_dat_o     (eng_dat_o),
        .eng_dat_i     (eng_dat_i)
`ifdef TRIVIUM_STREAM_CTRL_KS_CNT_EN
        ,
        .ks_cnt_o      (ks_cnt_o)
`endif
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    // Trivium state st[i-1] holds s_i.
    function automatic logic [287:0] trv_load(input logic [79:0] k, input logic [79:0] v);
        logic [287:0] s;
        s = '0;
        for (int i = 0; i < 80; i++) begin
            s[i]      = k[i];
            s[93 + i] = v[i];
        end
        s[285] = 1'b1;
        s[286] = 1'b1;
        s[287] = 1'b1;
        return s;
    endfunction

    function automatic logic trv_z(input logic [287:0] s);
        return s[65] ^ s[92] ^ s[161] ^ s[176] ^ s[242] ^ s[287];
    endfunction

    function automatic logic [287:0] trv_next(input logic [287:0] s);
        logic t1, t2, t3;
        logic [287:0] n;
        t1 = s[65] ^ s[92] ^ (s[90] & s[91]) ^ s[170];
        t2 = s[161] ^ s[176] ^ (s[174] & s[175]) ^ s[263];
        t3 = s[242] ^ s[287] ^ (s[285] & s[286]) ^ s[68];
        n = s;
        n[92:0]    = {s[91:0], t3};
        n[176:93]  = {s[175:93], t1};
        n[287:177] = {s[286:177], t2};
        return n;
    endfunction

    // Keystream byte number nbyte (LSB = earliest bit) after the 1152-clock warm-up.
    function automatic logic [7:0] golden_ks(input logic [79:0] k, input logic [79:0] v, input int nbyte);
        logic [287:0] s;
        logic [7:0]   r;
        s = trv_load(k, v);
        for (int i = 0; i < 1152 + nbyte * 8; i++) s = trv_next(s);
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i] = trv_z(s);
            s    = trv_next(s);
        end
        return r;
    endfunction

    // Behavioural cipher_engine: output is combinational on state and input bit.
    logic [287:0] eng_st = '0;

    always @(posedge clk_i) begin
        if (eng_ld_o) eng_st <= trv_load(eng_key_o, eng_iv_o);
        else if (eng_ce_o) eng_st <= trv_next(eng_st);
    end

    assign eng_dat_i = eng_dat_o ^ trv_z(eng_st);

    // Request a rekey from a negedge in IDLE/READY; returns in the LOAD cycle.
    task automatic do_start(input logic [79:0] k, input logic [79:0] v);
        start_i = 1'b1;
        key_i   = k;
        iv_i    = v;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    // Wait (bounded) until the controller offers in_ready_o.
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!in_ready_o && n < 1300) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (in_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_ready_timeout: in_ready_o=%b required 1", name, in_ready_o);
        end
    endtask

    // Offer one byte from READY; returns at the negedge where out_valid_o is first seen.
    task automatic send_byte(input logic [7:0] b, output logic [7:0] res,
                             output int lat, output int ce_cnt);
        lat     = 0;
        ce_cnt  = 0;
        res     = '0;
        in_valid_i = 1'b1;
        in_dat_i   = b;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (out_valid_o) begin
                lat = i;
                res = out_dat_o;
                break;
            end
            if (eng_ce_o) ce_cnt++;
            @(negedge clk_i);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++;
        if (start_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_start_ready: got %b required 1", start_ready_o);
        end
        checks++;
        if ({busy_o, eng_ce_o, eng_ld_o, out_valid_o, in_ready_o, eng_dat_o} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl_outs: got %b required 000000",
                     {busy_o, eng_ce_o, eng_ld_o, out_valid_o, in_ready_o, eng_dat_o});
        end
        checks++;
        if ({eng_key_o, eng_iv_o, out_dat_o} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_regs: key=%h iv=%h out=%h required 0", eng_key_o, eng_iv_o, out_dat_o);
        end
`ifdef TRIVIUM_STREAM_CTRL_KS_CNT_EN
        checks++;
        if (ks_cnt_o !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_ks_cnt: got %0d required 0", ks_cnt_o);
        end
`endif
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    // Start at edge 0 with all-zero key/IV and trace the load/warm-up timeline.
    task automatic test_warmup();
        int ld_cnt, ld_first, ce_cnt, ce_first, ce_last, busy_cnt, busy_late, rdy_first;
        ld_cnt = 0; ld_first = -1; ce_cnt = 0; ce_first = -1; ce_last = -1;
        busy_cnt = 0; busy_late = 0; rdy_first = -1;
        do_start(80'h0, 80'h0);
        for (int cyc = 1; cyc <= 1160; cyc++) begin
            if (eng_ld_o) begin
                ld_cnt++;
                if (ld_first < 0) ld_first = cyc;
            end
            if (eng_ce_o) begin
                ce_cnt++;
                if (ce_first < 0) ce_first = cyc;
                ce_last = cyc;
            end
            if (in_ready_o && rdy_first < 0) rdy_first = cyc;
            if (busy_o) begin
                if (rdy_first < 0) busy_cnt++;
                else busy_late++;
            end
            @(negedge clk_i);
        end
        checks++;
        if (ld_cnt !== 1 || ld_first !== 1) begin
            errors++;
            $display("[TB] FAIL warm_ld: count=%0d first=%0d required count=1 first=1", ld_cnt, ld_first);
        end
        checks++;
        if (ce_cnt !== 1153 || ce_first !== 1 || ce_last !== 1153) begin
            errors++;
            $display("[TB] FAIL warm_ce: count=%0d span=%0d..%0d required 1153 span 1..1153",
                     ce_cnt, ce_first, ce_last);
        end
        checks++;
        if (rdy_first !== 1154) begin
            errors++;
            $display("[TB] FAIL warm_first_ready: got cycle %0d required 1154", rdy_first);
        end
        checks++;
        if (busy_cnt !== 1153 || busy_late !== 0) begin
            errors++;
            $display("[TB] FAIL warm_busy: during=%0d after=%0d required 1153 and 0", busy_cnt, busy_late);
        end
    endtask

    // Zero plaintext exposes the raw keystream, LSB first.
    task automatic test_keystream();
        logic [7:0] res;
        int lat, cec;
        out_ready_i = 1'b1;
        send_byte(8'h00, res, lat, cec);
        checks++;
        if (lat !== DW + 1) begin
            errors++;
            $display("[TB] FAIL ks_latency: got %0d edges required %0d", lat, DW + 1);
        end
        checks++;
        if (cec !== DW) begin
            errors++;
            $display("[TB] FAIL ks_ce_cycles: got %0d required %0d", cec, DW);
        end
        checks++;
        if (res !== golden_ks(80'h0, 80'h0, 0)) begin
            errors++;
            $display("[TB] FAIL ks_byte0: got %h required %h", res, golden_ks(80'h0, 80'h0, 0));
        end
        @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ks_back_to_ready: out_valid=%b in_ready=%b required 0 1", out_valid_o, in_ready_o);
        end
        send_byte(8'h00, res, lat, cec);
        checks++;
        if (res !== golden_ks(80'h0, 80'h0, 1)) begin
            errors++;
            $display("[TB] FAIL ks_byte1: got %h required %h", res, golden_ks(80'h0, 80'h0, 1));
        end
        @(negedge clk_i);
    endtask

    // Encrypt 0xA5, rekey with the same key/IV, decrypt back to 0xA5.
    task automatic test_roundtrip();
        logic [7:0] ct, pt;
        int lat, cec;
        do_start(KEY_A, IV_A);
        checks++;
        if (eng_key_o !== KEY_A || eng_iv_o !== IV_A) begin
            errors++;
            $display("[TB] FAIL rt_key_iv: key=%h iv=%h required %h %h", eng_key_o, eng_iv_o, KEY_A, IV_A);
        end
        wait_ready("rt_enc");
        send_byte(8'hA5, ct, lat, cec);
        checks++;
        if (ct !== (8'hA5 ^ golden_ks(KEY_A, IV_A, 0))) begin
            errors++;
            $display("[TB] FAIL rt_cipher: got %h required %h", ct, 8'hA5 ^ golden_ks(KEY_A, IV_A, 0));
        end
        @(negedge clk_i);
        do_start(KEY_A, IV_A);
        wait_ready("rt_dec");
        send_byte(ct, pt, lat, cec);
        checks++;
        if (pt !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL rt_plain: got %h required a5", pt);
        end
        @(negedge clk_i);
    endtask

    // Back-pressure in OUT for 20 cycles.
    task automatic test_hold();
        logic [7:0] res, held;
        int lat, cec, bad;
        out_ready_i = 1'b0;
        send_byte(8'h5A, res, lat, cec);
        held = out_dat_o;
        bad  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (out_dat_o !== held || out_valid_o !== 1'b1 || eng_ce_o !== 1'b0 ||
                in_ready_o !== 1'b0 || start_ready_o !== 1'b0 || busy_o !== 1'b0) bad++;
        end
        checks++;
        if (lat !== DW + 1 || bad !== 0) begin
            errors++;
            $display("[TB] FAIL hold_stable: latency=%0d bad_cycles=%0d required %0d and 0", lat, bad, DW + 1);
        end
        checks++;
        if (res !== (8'h5A ^ golden_ks(KEY_A, IV_A, 1))) begin
            errors++;
            $display("[TB] FAIL hold_data: got %h required %h", res, 8'h5A ^ golden_ks(KEY_A, IV_A, 1));
        end
        out_ready_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_release: out_valid=%b in_ready=%b required 0 1", out_valid_o, in_ready_o);
        end
    endtask

    // Start beats data in READY; then reset in the middle of warm-up.
    task automatic test_start_priority_and_reset();
        start_i    = 1'b1;
        key_i      = KEY_A;
        iv_i       = IV_A;
        in_valid_i = 1'b1;
        in_dat_i   = 8'h3C;
        #1;
        checks++;
        if (in_ready_o !== 1'b0 || start_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL prio_ready: in_ready=%b start_ready=%b required 0 1", in_ready_o, start_ready_o);
        end
        @(negedge clk_i);
        start_i    = 1'b0;
        in_valid_i = 1'b0;
        checks++;
        if (eng_ld_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL prio_load: eng_ld=%b busy=%b required 1 1", eng_ld_o, busy_o);
        end
        repeat (501) @(negedge clk_i);
        checks++;
        if (eng_ce_o !== 1'b1 || busy_o !== 1'b1 || in_ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_warmup: ce=%b busy=%b in_ready=%b required 1 1 0", eng_ce_o, busy_o, in_ready_o);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if (start_ready_o !== 1'b1 || {busy_o, eng_ce_o, eng_ld_o, out_valid_o, in_ready_o} !== 5'b0 ||
            eng_key_o !== 80'h0 || eng_iv_o !== 80'h0) begin
            errors++;
            $display("[TB] FAIL async_reset: start_ready=%b ctrl=%b key=%h iv=%h required 1 00000 0 0",
                     start_ready_o, {busy_o, eng_ce_o, eng_ld_o, out_valid_o, in_ready_o}, eng_key_o, eng_iv_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    // A fresh start after reset works normally.
    task automatic test_after_reset();
        logic [7:0] res;
        int lat, cec;
        do_start(80'h0, 80'h0);
        wait_ready("after_reset");
        send_byte(8'h00, res, lat, cec);
        checks++;
        if (res !== golden_ks(80'h0, 80'h0, 0)) begin
            errors++;
            $display("[TB] FAIL after_reset_ks: got %h required %h", res, golden_ks(80'h0, 80'h0, 0));
        end
        @(negedge clk_i);
    endtask

`ifdef TRIVIUM_STREAM_CTRL_KS_CNT_EN
    task automatic test_ks_cnt();
        logic [7:0] res;
        int lat, cec;
        do_start(KEY_A, IV_A);
        checks++;
        if (ks_cnt_o !== 32'd0) begin
            errors++;
            $display("[TB] FAIL ks_cnt_clear1: got %0d required 0", ks_cnt_o);
        end
        wait_ready("ks_cnt");
        for (int i = 0; i < 3; i++) begin
            send_byte(8'(i), res, lat, cec);
            @(negedge clk_i);
        end
        checks++;
        if (ks_cnt_o !== 32'd3) begin
            errors++;
            $display("[TB] FAIL ks_cnt_three: got %0d required 3", ks_cnt_o);
        end
        do_start(KEY_A, IV_A);
        checks++;
        if (ks_cnt_o !== 32'd0) begin
            errors++;
            $display("[TB] FAIL ks_cnt_clear2: got %0d required 0", ks_cnt_o);
        end
    endtask
`endif

    // Run every scenario in order, then report.
    initial begin
        $display("[TB] starting trivium_stream_ctrl bench");
        test_reset();
        test_warmup();
        test_keystream();
        test_roundtrip();
        test_hold();
        test_start_priority_and_reset();
        test_after_reset();
`ifdef TRIVIUM_STREAM_CTRL_KS_CNT_EN
        test_ks_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
